regulator_cal_sequencer: RTL and testbench
==========================================

Name: regulator_cal_sequencer

Overview:
Sequences one calibration run of the ring-oscillator frequency regulator. It latches a target period and tolerance, and derives the fmin/fmax band registers. It then enables the ring oscillator, waits a warm-up interval, and releases the regulator's init. Finally it monitors the regulator's window-done, increment and decrement flags to declare lock, loss of lock or timeout. It sits between host/config logic and frequency_requlator plus ring_oscillator.

Parameters:
W, 8, width of period/band values
WARMUP_CYCLES, 16, clk_frequency cycles between osc_en rising and reg_init rising
LOCK_WINDOWS, 4, consecutive clean windows required to declare lock
MAX_WINDOWS, 64, windows allowed in TRACK before timeout

Ports:
clk_frequency  in  1  system clock
rst_frequency  in  1  synchronous reset, active-high
start  in  1  begin run (sampled in IDLE/FAIL only)
abort  in  1  return to IDLE
setperiod_req  in  W  target period
tol  in  W  band half-width
co_passed  in  1  regulator window-done (level; rising edge used)
increment  in  1  regulator adjust-up flag
decrement  in  1  regulator adjust-down flag
osc_en  out  1  ring oscillator enable
reg_init  out  1  regulator init (held high while running)
setperiod  out  W  registered target to regulator
fmin  out  W  registered slow-side bound (larger period)
fmax  out  W  registered fast-side bound (smaller period)
busy  out  1  high in CONFIG/WARMUP/TRACK/LOCKED
locked  out  1  high in LOCKED
timeout  out  1  high in FAIL
cfg_err  out  1  one-cycle pulse on rejected start
lock_lost  out  1  one-cycle pulse on LOCKED->TRACK

Behaviour:
- Clock and reset: one clock, clk_frequency. Reset is rst_frequency, synchronous and active-high.
- Reset values: all outputs are 0 and the state is IDLE. The counters and the co_passed edge register clear to 0.
- States: IDLE, CONFIG, WARMUP, TRACK, LOCKED, FAIL. All outputs are registered.
- IDLE, start=1, setperiod_req!=0 and tol!=0:
  - latch setperiod=setperiod_req
  - fmin=min(2^W-1, sp+tol), computed at W+1 bits and saturated
  - fmax=max(1, sp-tol), floor saturated at 1
  - go to CONFIG
- IDLE, start=1 with sp==0 or tol==0: cfg_err pulses for 1 cycle and the state stays IDLE.
- CONFIG: lasts 1 cycle. Next cycle osc_en=1 and the state is WARMUP, with the counter loaded to WARMUP_CYCLES-1.
- WARMUP: decrement the counter. When the counter is 0, set reg_init=1 the next cycle and enter TRACK, with win_cnt=lock_cnt=0 and dirty=0.
- Window edge: win_edge = co_passed & ~co_passed_q.
- dirty flag:
  - set by increment|decrement on any TRACK/LOCKED cycle
  - cleared on win_edge
  - the window is evaluated as dirty_next = dirty | increment | decrement on the same cycle as win_edge
- TRACK on win_edge:
  - win_cnt++
  - clean window: lock_cnt++; dirty window: lock_cnt=0
  - if lock_cnt reaches LOCK_WINDOWS, go to LOCKED (locked=1 the next cycle)
  - else if win_cnt reaches MAX_WINDOWS, go to FAIL
  - lock takes priority when both occur on the same edge
- LOCKED: a dirty window pulses lock_lost and goes to TRACK with counters and dirty cleared. osc_en and reg_init stay high.
- FAIL: timeout=1, osc_en=0, reg_init=0. setperiod/fmin/fmax hold their values. start re-runs the IDLE start check (retry with new config).
- abort: highest priority below reset. From any state, go to IDLE the next cycle with osc_en, reg_init, busy, locked and timeout at 0. Band registers hold their values.
- start while busy: ignored.
- Counter widths: clog2(param)+1. win_cnt saturates and never wraps.

Decomposition:
- Shared package regcal_pkg:
  - state enum (6 states, 3-bit)
  - constants for default WARMUP_CYCLES, LOCK_WINDOWS, MAX_WINDOWS
  - a saturating add/sub function for the band
- One sub-module, window_monitor:
  - co_passed edge detect
  - dirty flag
  - lock_cnt / win_cnt
  - outputs win_edge, clean, lock_hit, max_hit
- The top module holds the FSM and the band registers.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 and busy=0. start with sp=125, tol=35 -> fmin=160, fmax=90 visible one cycle after start. osc_en rises the next cycle; reg_init rises 16 cycles after osc_en.
- Four clean co_passed pulses (no inc/dec) -> locked=1 on the cycle after the 4th edge, and busy stays 1.
- Pattern clean, clean, dirty (increment asserted on the same cycle as the edge), then 4 clean -> lock only after the 7th edge. Once LOCKED, a decrement pulse followed by an edge -> lock_lost pulse, locked=0.
- All 64 windows dirty -> timeout=1 after the 64th edge, with osc_en=0 and reg_init=0. start with sp=200, tol=100 -> fmin=255 (saturated), fmax=100.
- Config rejection: start with tol=0 -> cfg_err one-cycle pulse and the state stays IDLE. start with sp=10, tol=20 -> fmax=1.
- abort mid-WARMUP and abort in LOCKED -> IDLE the next cycle with outputs low. start asserted during TRACK -> no effect. co_passed held high 5 cycles -> counts as one window.

Source files
------------

// File: rtl/regcal_pkg.sv
// Shared types, default parameters and band arithmetic for the regulator
// calibration sequencer.
package regcal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_WARMUP,
    S_TRACK,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam int DEF_WARMUP_CYCLES = 16;
  localparam int DEF_LOCK_WINDOWS  = 4;
  localparam int DEF_MAX_WINDOWS   = 64;

  // Slow-side bound: sp + tol, clamped to the largest w-bit value.
  function automatic logic [31:0] band_hi(input logic [31:0] sp, input logic [31:0] tl,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, sp} + {1'b0, tl};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  // Fast-side bound: sp - tol, floored at 1 so the regulator never sees a zero period.
  function automatic logic [31:0] band_lo(input logic [31:0] sp, input logic [31:0] tl);
    return (sp > tl) ? (sp - tl) : 32'd1;
  endfunction

endpackage

// File: rtl/window_monitor.sv
// Tracks regulator windows: co_passed edge detect, per-window dirty flag,
// consecutive clean-window and total-window counters.
module window_monitor #(
  parameter int LOCK_WINDOWS = 4,
  parameter int MAX_WINDOWS  = 64
) (
  input  logic clk_frequency,
  input  logic rst_frequency,
  input  logic co_passed,
  input  logic increment,
  input  logic decrement,
  input  logic track,
  input  logic clear,
  output logic win_edge,
  output logic clean,
  output logic lock_hit,
  output logic max_hit
);

  localparam int LCW = $clog2(LOCK_WINDOWS) + 1;
  localparam int WCW = $clog2(MAX_WINDOWS) + 1;

  logic           co_q;
  logic           dirty;
  logic [LCW-1:0] lock_cnt;
  logic [WCW-1:0] win_cnt;

  assign win_edge = co_passed & ~co_q;
  // Adjust flags on the edge cycle still belong to the window being closed.
  assign clean    = ~(dirty | increment | decrement);
  assign lock_hit = track & win_edge & clean & (lock_cnt >= LCW'(LOCK_WINDOWS - 1));
  assign max_hit  = track & win_edge & (win_cnt >= WCW'(MAX_WINDOWS - 1));

  always_ff @(posedge clk_frequency) begin
    if (rst_frequency) begin
      co_q     <= 1'b0;
      dirty    <= 1'b0;
      lock_cnt <= '0;
      win_cnt  <= '0;
    end else begin
      co_q <= co_passed;
      if (clear) begin
        dirty    <= 1'b0;
        lock_cnt <= '0;
        win_cnt  <= '0;
      end else begin
        dirty <= win_edge ? 1'b0 : (dirty | increment | decrement);
        if (track && win_edge) begin
          if (win_cnt != WCW'(MAX_WINDOWS)) win_cnt <= win_cnt + 1'b1;
          if (!clean)                                  lock_cnt <= '0;
          else if (lock_cnt != LCW'(LOCK_WINDOWS))     lock_cnt <= lock_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regulator_cal_sequencer.sv
// Calibration run sequencer: latches the target band, enables the ring
// oscillator, warms up, releases regulator init and judges lock/timeout.
module regulator_cal_sequencer
  import regcal_pkg::*;
#(
  parameter int W             = 8,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int LOCK_WINDOWS  = DEF_LOCK_WINDOWS,
  parameter int MAX_WINDOWS   = DEF_MAX_WINDOWS
) (
  input  logic         clk_frequency,
  input  logic         rst_frequency,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] setperiod_req,
  input  logic [W-1:0] tol,
  input  logic         co_passed,
  input  logic         increment,
  input  logic         decrement,
  output logic         osc_en,
  output logic         reg_init,
  output logic [W-1:0] setperiod,
  output logic [W-1:0] fmin,
  output logic [W-1:0] fmax,
  output logic         busy,
  output logic         locked,
  output logic         timeout,
  output logic         cfg_err,
  output logic         lock_lost
);

  localparam int WUW = $clog2(WARMUP_CYCLES) + 1;

  state_t         state, state_n;
  logic [WUW-1:0] wu_cnt;
  logic           load, cfg_ok, cfg_err_n, lock_lost_n;
  logic           win_edge, clean, lock_hit, max_hit;
  logic           track, win_clear;

  assign cfg_ok    = (setperiod_req != '0) && (tol != '0);
  assign track     = (state == S_TRACK);
  // Window state lives only while tracking or locked; re-entering TRACK restarts it.
  assign win_clear = !(state == S_TRACK || state == S_LOCKED) || lock_lost_n;

  window_monitor #(
    .LOCK_WINDOWS(LOCK_WINDOWS),
    .MAX_WINDOWS (MAX_WINDOWS)
  ) u_win (
    .clk_frequency(clk_frequency),
    .rst_frequency(rst_frequency),
    .co_passed    (co_passed),
    .increment    (increment),
    .decrement    (decrement),
    .track        (track),
    .clear        (win_clear),
    .win_edge     (win_edge),
    .clean        (clean),
    .lock_hit     (lock_hit),
    .max_hit      (max_hit)
  );

  always_comb begin
    state_n     = state;
    load        = 1'b0;
    cfg_err_n   = 1'b0;
    lock_lost_n = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FAIL: begin
          if (start) begin
            if (cfg_ok) begin
              state_n = S_CONFIG;
              load    = 1'b1;
            end else begin
              cfg_err_n = 1'b1;
            end
          end
        end
        S_CONFIG: state_n = S_WARMUP;
        S_WARMUP: if (wu_cnt == '0) state_n = S_TRACK;
        S_TRACK: begin
          if (lock_hit)     state_n = S_LOCKED;
          else if (max_hit) state_n = S_FAIL;
        end
        S_LOCKED: begin
          if (win_edge && !clean) begin
            state_n     = S_TRACK;
            lock_lost_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_frequency) begin
    if (rst_frequency) begin
      state     <= S_IDLE;
      wu_cnt    <= '0;
      setperiod <= '0;
      fmin      <= '0;
      fmax      <= '0;
      osc_en    <= 1'b0;
      reg_init  <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      cfg_err   <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_CONFIG)                     wu_cnt <= WUW'(WARMUP_CYCLES - 1);
      else if (state == S_WARMUP && wu_cnt != '0) wu_cnt <= wu_cnt - 1'b1;
      if (load) begin
        setperiod <= setperiod_req;
        fmin      <= W'(band_hi(32'(setperiod_req), 32'(tol), W));
        fmax      <= W'(band_lo(32'(setperiod_req), 32'(tol)));
      end
      // Status outputs are decoded from the next state so they align with it.
      osc_en    <= (state_n == S_WARMUP) || (state_n == S_TRACK) || (state_n == S_LOCKED);
      reg_init  <= (state_n == S_TRACK) || (state_n == S_LOCKED);
      busy      <= (state_n == S_CONFIG) || (state_n == S_WARMUP) ||
                   (state_n == S_TRACK)  || (state_n == S_LOCKED);
      locked    <= (state_n == S_LOCKED);
      timeout   <= (state_n == S_FAIL);
      cfg_err   <= cfg_err_n;
      lock_lost <= lock_lost_n;
    end
  end

endmodule

// File: tb/tb_regulator_cal_sequencer.sv
// Scoreboard bench: stimulus tasks push predicted output snapshots with their
// cycle; a monitor compares every observed output change against the queue.
module tb_regulator_cal_sequencer;

  logic       clk_frequency = 1'b0;
  logic       rst_frequency = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic [7:0] setperiod_req = '0, tol = '0;
  logic       co_passed = 1'b0, increment = 1'b0, decrement = 1'b0;
  logic       osc_en, reg_init, busy, locked, timeout, cfg_err, lock_lost;
  logic [7:0] setperiod, fmin, fmax;

  regulator_cal_sequencer dut (
    .clk_frequency(clk_frequency), .rst_frequency(rst_frequency),
    .start(start), .abort(abort), .setperiod_req(setperiod_req), .tol(tol),
    .co_passed(co_passed), .increment(increment), .decrement(decrement),
    .osc_en(osc_en), .reg_init(reg_init), .setperiod(setperiod),
    .fmin(fmin), .fmax(fmax), .busy(busy), .locked(locked),
    .timeout(timeout), .cfg_err(cfg_err), .lock_lost(lock_lost)
  );

  always #5 clk_frequency = ~clk_frequency;

  int cyc = 0;
  always @(posedge clk_frequency) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [30:0] vec;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  bit mon_en = 1'b0;
  logic [30:0] prev_v;

  // Reference model, abstract run modes
  localparam int M_IDLE = 0, M_WARM = 1, M_TRACK = 2, M_LOCKED = 3, M_FAIL = 4;
  int   mode = M_IDLE, wins = 0, streak = 0;
  bit   pending = 1'b0;
  bit   m_osc = 0, m_init = 0, m_busy = 0, m_locked = 0, m_to = 0;
  logic [7:0] m_sp = '0, m_fmin = '0, m_fmax = '0;

  function automatic logic [30:0] dut_v();
    return {osc_en, reg_init, busy, locked, timeout, cfg_err, lock_lost, setperiod, fmin, fmax};
  endfunction

  function automatic logic [30:0] mv(input bit err, input bit lost);
    return {m_osc, m_init, m_busy, m_locked, m_to, err, lost, m_sp, m_fmin, m_fmax};
  endfunction

  task automatic expect_at(input int c, input logic [30:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  always @(negedge clk_frequency) begin
    exp_t e;
    logic [30:0] cur;
    if (mon_en) begin
      cur = dut_v();
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_change cyc=%0d got=%h required_at=%0d required=%h", cyc, cur, e.cyc, e.vec);
      end
      if (cur !== prev_v) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=%h", cyc, cur, prev_v);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.vec !== cur) begin
            failures++;
            $display("FAIL out_change cyc=%0d got=%h required_cyc=%0d required=%h", cyc, cur, e.cyc, e.vec);
          end
        end
      end
      prev_v = cur;
    end
  end

  task automatic tick();
    @(negedge clk_frequency);
  endtask

  task automatic do_abort();
    int k;
    k = cyc;
    abort = 1'b1;
    if (mode != M_IDLE) begin
      m_osc = 0; m_init = 0; m_busy = 0; m_locked = 0; m_to = 0;
      expect_at(k + 1, mv(0, 0));
    end
    mode = M_IDLE;
    pending = 1'b0;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // abort_after: 0 runs through warm-up into TRACK, otherwise aborts that many cycles in.
  task automatic start_run(input int sp, input int t, input int abort_after);
    int k, s, d;
    k = cyc;
    start = 1'b1;
    setperiod_req = 8'(sp);
    tol = 8'(t);
    if (mode == M_WARM || mode == M_TRACK || mode == M_LOCKED) begin
      tick();
      start = 1'b0;
      tick();
    end else if (sp == 0 || t == 0) begin
      expect_at(k + 1, mv(1, 0));
      expect_at(k + 2, mv(0, 0));
      tick();
      start = 1'b0;
      tick();
      tick();
    end else begin
      s = sp + t;
      d = sp - t;
      m_sp = 8'(sp);
      m_fmin = (s > 255) ? 8'd255 : 8'(s);
      m_fmax = (d < 1) ? 8'd1 : 8'(d);
      m_busy = 1; m_to = 0; m_locked = 0;
      expect_at(k + 1, mv(0, 0));
      m_osc = 1;
      expect_at(k + 2, mv(0, 0));
      mode = M_WARM;
      tick();
      start = 1'b0;
      if (abort_after > 0) begin
        repeat (abort_after - 1) tick();
        do_abort();
      end else begin
        m_init = 1;
        expect_at(k + 18, mv(0, 0));
        mode = M_TRACK; wins = 0; streak = 0; pending = 1'b0;
        repeat (17) tick();
      end
    end
  endtask

  task automatic model_edge(input int c, input bit d);
    bit dw;
    dw = pending | d;
    pending = 1'b0;
    if (mode == M_TRACK) begin
      wins++;
      streak = dw ? 0 : streak + 1;
      if (streak == 4) begin
        mode = M_LOCKED; m_locked = 1;
        expect_at(c, mv(0, 0));
      end else if (wins == 64) begin
        mode = M_FAIL; m_osc = 0; m_init = 0; m_busy = 0; m_to = 1;
        expect_at(c, mv(0, 0));
      end
    end else if (mode == M_LOCKED && dw) begin
      mode = M_TRACK; wins = 0; streak = 0; m_locked = 0;
      expect_at(c, mv(0, 1));
      expect_at(c + 1, mv(0, 0));
    end
  endtask

  task automatic window(input bit d, input int hold, input int gap);
    int k;
    k = cyc;
    co_passed = 1'b1;
    if (d) begin
      if ($urandom_range(0, 1) == 1) increment = 1'b1;
      else decrement = 1'b1;
    end
    model_edge(k + 1, d);
    tick();
    increment = 1'b0;
    decrement = 1'b0;
    repeat (hold - 1) tick();
    co_passed = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic dirty_pulse(input bit use_dec);
    if (use_dec) decrement = 1'b1;
    else increment = 1'b1;
    if (mode == M_TRACK || mode == M_LOCKED) pending = 1'b1;
    tick();
    increment = 1'b0;
    decrement = 1'b0;
    tick();
  endtask

  task automatic rand_windows(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) dirty_pulse(1'($urandom_range(0, 1)));
      window($urandom_range(0, 3) == 0, $urandom_range(1, 5), $urandom_range(1, 3));
    end
  endtask

  initial begin
    rst_frequency = 1'b1;
    repeat (3) tick();
    rst_frequency = 1'b0;
    tick();
    checks++;
    if (dut_v() !== 31'd0) begin
      failures++;
      $display("FAIL reset_state got=%h required=0", dut_v());
    end
    prev_v = dut_v();
    mon_en = 1'b1;

    // Basic run and clean lock
    start_run(125, 35, 0);
    repeat (4) window(1'b0, 1, 2);
    do_abort();

    // Streak reset by a dirty edge, then loss of lock and other TRACK behaviour
    start_run(125, 35, 0);
    window(1'b0, 1, 2);
    window(1'b0, 1, 2);
    window(1'b1, 1, 2);
    repeat (4) window(1'b0, 1, 2);
    dirty_pulse(1'b1);
    window(1'b0, 1, 2);
    start_run(77, 3, 0);
    window(1'b0, 5, 2);
    rand_windows(20);
    do_abort();

    // Timeout, then retry from FAIL with a saturating band
    start_run($urandom_range(20, 230), $urandom_range(1, 20), 0);
    repeat (64) window(1'b1, 1, 1);
    repeat (3) tick();
    start_run(200, 100, 0);
    window(1'b0, 2, 1);
    do_abort();

    // Rejected configs and floor saturation
    start_run(50, 0, 0);
    start_run(0, 5, 0);
    start_run(10, 20, 0);
    do_abort();

    // Abort in warm-up
    start_run($urandom_range(1, 255), $urandom_range(1, 255), 8);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      start_run($urandom_range(0, 255), $urandom_range(0, 60), 0);
      rand_windows(12);
      do_abort();
    end

    repeat (5) tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
